// File: rtl/instr_loader.sv
// rtl/instr_loader.sv - packs decoded instruction fields into 9-bit words and writes them to instruction memory
module instr_loader #(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              init,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] word_count,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_op,
    input  logic [2:0]        in_ra,
    input  logic [2:0]        in_rb,
    input  logic [5:0]        in_imm,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [8:0]        im_wdata,
    input  logic              im_ack,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] loaded
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] total_q, total_d;
    logic [ADDR_W-1:0] acc_q, acc_d;
    logic [ADDR_W-1:0] loaded_q, loaded_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  fill_q, fill_d;
    logic [8:0]        mem_q [DEPTH];

    logic       active, fifo_full, fifo_empty;
    logic       push, pop, flush, ready_c, we_c;
    logic [8:0] enc;

    // Branches carry a 6-bit offset in place of both register fields.
    assign enc = (in_op == 3'b111) ? {3'b111, in_imm} : {in_op, in_ra, in_rb};

    assign active     = (state_q == S_LOAD) || (state_q == S_DRAIN);
    assign fifo_full  = (fill_q == CNT_W'(DEPTH));
    assign fifo_empty = (fill_q == '0);

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        total_d  = total_q;
        acc_d    = acc_q;
        loaded_d = loaded_q;
        ready_c  = 1'b0;
        we_c     = 1'b0;
        push     = 1'b0;
        pop      = 1'b0;
        flush    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    addr_d   = base_addr;
                    total_d  = word_count;
                    acc_d    = '0;
                    loaded_d = '0;
                    flush    = 1'b1;
                    state_d  = (word_count == '0) ? S_DONE : S_LOAD;
                end
            end
            S_LOAD:  ready_c = !fifo_full && (acc_q < total_q);
            S_DRAIN: ready_c = 1'b0;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (active) begin
            we_c = !fifo_empty;
            pop  = we_c && im_ack;
            push = in_valid && ready_c;
            if (pop) begin
                addr_d   = addr_q + ADDR_W'(1);
                loaded_d = loaded_q + ADDR_W'(1);
            end
            if (push) begin
                acc_d = acc_q + ADDR_W'(1);
            end
            if (state_q == S_LOAD && acc_d == total_q) begin
                state_d = S_DRAIN;
            end
            if (state_q == S_DRAIN && loaded_d == total_q) begin
                state_d = S_DONE;
            end
            // An ack in the abort cycle still counts: the memory did take that word.
            if (abort) begin
                state_d = S_IDLE;
                flush   = 1'b1;
                push    = 1'b0;
            end
        end

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            fill_d   = '0;
        end else begin
            wr_ptr_d = wr_ptr_q + PTR_W'(push);
            rd_ptr_d = rd_ptr_q + PTR_W'(pop);
            fill_d   = fill_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk or posedge init) begin
        if (init) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            total_q  <= '0;
            acc_q    <= '0;
            loaded_q <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fill_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            total_q  <= total_d;
            acc_q    <= acc_d;
            loaded_q <= loaded_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            fill_q   <= fill_d;
            if (push) begin
                mem_q[wr_ptr_q] <= enc;
            end
        end
    end

    assign in_ready = ready_c;
    assign im_we    = we_c;
    assign im_addr  = addr_q;
    assign im_wdata = we_c ? mem_q[rd_ptr_q] : 9'd0;
    assign busy     = active;
    assign done     = (state_q == S_DONE);
    assign loaded   = loaded_q;

endmodule

// File: tb/tb_instr_loader.sv
// tb/tb_instr_loader.sv - directed self-checking bench for instr_loader
module tb_instr_loader;

    logic       clk = 1'b0;
    logic       init, start, abort;
    logic [7:0] base_addr, word_count;
    logic       in_valid, in_ready;
    logic [2:0] in_op, in_ra, in_rb;
    logic [5:0] in_imm;
    logic       im_we;
    logic [7:0] im_addr;
    logic [8:0] im_wdata;
    logic       im_ack, busy, done;
    logic [7:0] loaded;

    int vectors = 0;
    int miscompares = 0;

    // Encodings of ops 000..111 with ra=101, rb=010, imm=110011.
    logic [8:0] exp_data [8] = '{9'h02A, 9'h06A, 9'h0AA, 9'h0EA, 9'h12A, 9'h16A, 9'h1AA, 9'h1F3};

    instr_loader #(.ADDR_W(8), .DEPTH(4)) dut (
        .clk(clk), .init(init), .start(start), .abort(abort),
        .base_addr(base_addr), .word_count(word_count),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_ra(in_ra), .in_rb(in_rb), .in_imm(in_imm),
        .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata), .im_ack(im_ack),
        .busy(busy), .done(done), .loaded(loaded)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_beat(input int n);
        in_op  = 3'(n);
        in_ra  = 3'b101;
        in_rb  = 3'b010;
        in_imm = 6'b110011;
    endtask

    task automatic do_start(input logic [7:0] b, input logic [7:0] c);
        base_addr  = b;
        word_count = c;
        start      = 1'b1;
        tick();
        start      = 1'b0;
    endtask

    // Streams count beats; im_ack is held low for the first stall cycles.
    task automatic run_load(input string name, input logic [7:0] b, input int count,
                            input int stall, input int stall_accepts);
        int ni = 0;
        int nw = 0;
        int cyc = 0;
        bit done_seen = 0;
        logic [7:0] ea;
        do_start(b, 8'(count));
        check({name, "_busy_after_start"}, busy, 1);
        check({name, "_ready_after_start"}, in_ready, 1);
        check({name, "_we_after_start"}, im_we, 0);
        im_ack = (stall == 0);
        while (!done_seen && cyc < 100) begin
            if (done) begin
                done_seen = 1;
                check({name, "_writes"}, nw, count);
                check({name, "_loaded"}, loaded, count);
                check({name, "_busy_at_done"}, busy, 0);
            end else begin
                if (stall > 0 && cyc == stall) begin
                    check({name, "_stall_accepts"}, ni, stall_accepts);
                    check({name, "_stall_ready"}, in_ready, 0);
                    im_ack = 1'b1;
                end
                in_valid = (ni < count);
                set_beat(ni);
                if (im_we) begin
                    ea = b + 8'(nw);
                    check({name, "_in_range"}, nw < count, 1);
                    check({name, "_addr"}, im_addr, ea);
                    check({name, "_data"}, im_wdata, exp_data[nw % 8]);
                    if (im_ack) nw++;
                end
                if (in_valid && in_ready) ni++;
                tick();
                cyc++;
            end
        end
        in_valid = 1'b0;
        check({name, "_done_seen"}, done_seen, 1);
        tick();
        check({name, "_done_once"}, done, 0);
        check({name, "_loaded_hold"}, loaded, count);
    endtask

    initial begin
        int nw;
        int cyc;
        init = 1'b1; start = 1'b0; abort = 1'b0;
        base_addr = '0; word_count = '0;
        in_valid = 1'b0; in_op = '0; in_ra = '0; in_rb = '0; in_imm = '0;
        im_ack = 1'b0;
        tick();
        tick();
        check("rst_in_ready", in_ready, 0);
        check("rst_im_we", im_we, 0);
        check("rst_im_addr", im_addr, 0);
        check("rst_im_wdata", im_wdata, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_loaded", loaded, 0);
        init = 1'b0;
        tick();

        run_load("sweep", 8'h10, 8, 0, 0);
        run_load("bp", 8'h40, 6, 10, 4);
        run_load("wrap", 8'hFE, 4, 0, 0);

        do_start(8'h50, 8'h00);
        check("zero_done", done, 1);
        check("zero_busy", busy, 0);
        check("zero_we", im_we, 0);
        check("zero_ready", in_ready, 0);
        tick();
        check("zero_done_clear", done, 0);
        check("zero_loaded", loaded, 0);

        do_start(8'h20, 8'h08);
        im_ack = 1'b1;
        nw = 0;
        cyc = 0;
        while (nw < 3 && cyc < 50) begin
            in_valid = 1'b1;
            set_beat(cyc);
            if (im_we && im_ack) nw++;
            tick();
            cyc++;
        end
        check("abort_acks", nw, 3);
        check("abort_loaded_before", loaded, 3);
        abort = 1'b1;
        im_ack = 1'b0;
        in_valid = 1'b0;
        tick();
        abort = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_we", im_we, 0);
        check("abort_ready", in_ready, 0);
        check("abort_loaded", loaded, 3);
        tick();
        check("abort_no_done", done, 0);
        run_load("restart", 8'h30, 2, 0, 0);

        do_start(8'h60, 8'h08);
        im_ack = 1'b0;
        in_valid = 1'b1;
        set_beat(0);
        tick();
        set_beat(1);
        tick();
        in_valid = 1'b0;
        check("midrst_we_before", im_we, 1);
        check("midrst_data_before", im_wdata, 9'h02A);
        init = 1'b1;
        #1;
        check("midrst_in_ready", in_ready, 0);
        check("midrst_im_we", im_we, 0);
        check("midrst_im_addr", im_addr, 0);
        check("midrst_im_wdata", im_wdata, 0);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_loaded", loaded, 0);
        tick();
        init = 1'b0;
        im_ack = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("midrst_no_we", im_we, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
